// File: rtl/qenc_pkg.sv
// Shared constants, quadrature phase encoding and step decode for the encoder front end.
// Optional index channel support is enabled with QENC_INDEX_EN (see quad_encoder_counter).
package qenc_pkg;

    localparam int POS_W          = 10;
    localparam int FILTER_LEN_DEF = 3;

    localparam logic [1:0] PH_0 = 2'b00;
    localparam logic [1:0] PH_1 = 2'b01;
    localparam logic [1:0] PH_2 = 2'b11;
    localparam logic [1:0] PH_3 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_e;

    function automatic logic [1:0] phase_fwd(input logic [1:0] ph);
        logic [1:0] nxt;
        nxt = PH_0;
        case (ph)
            PH_0:    nxt = PH_1;
            PH_1:    nxt = PH_2;
            PH_2:    nxt = PH_3;
            default: nxt = PH_0;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] phase_rev(input logic [1:0] ph);
        logic [1:0] nxt;
        nxt = PH_0;
        case (ph)
            PH_0:    nxt = PH_3;
            PH_3:    nxt = PH_2;
            PH_2:    nxt = PH_1;
            default: nxt = PH_0;
        endcase
        return nxt;
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] curr);
        step_e s;
        if (prev == curr)                 s = STEP_NONE;
        else if (curr == phase_fwd(prev)) s = STEP_UP;
        else if (curr == phase_rev(prev)) s = STEP_DOWN;
        else                              s = STEP_ILLEGAL;
        return s;
    endfunction

endpackage

// File: rtl/qenc_filter.sv
// Two-flop synchroniser followed by a glitch filter: the output follows the
// synchronised line only after FILTER_LEN consecutive differing samples.
module qenc_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam logic [3:0] RUN_TC = 4'(FILTER_LEN - 1);

    logic [1:0] sync_q;
    logic [3:0] run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            run_q  <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            // Any sample agreeing with the filtered value restarts the run.
            if (sync_q[1] == filt) begin
                run_q <= '0;
            end else if (run_q == RUN_TC) begin
                filt  <= sync_q[1];
                run_q <= '0;
            end else begin
                run_q <= run_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder with modulo-PPR count and mid-centred signed position.
// Define QENC_INDEX_EN to add the Z index channel (zeroes count on Z rise at phase 00).
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_z,
    input  logic [POS_W-1:0]        ppr,
    input  logic                    clear,
    output logic [POS_W-1:0]        count,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

    logic              a_f;
    logic              b_f;
    logic [1:0]        ab_f;
    logic [1:0]        ab_q;
    logic              clear_q;
    logic              index_hit;
    step_e             step_k;

    logic [POS_W-1:0]  half_ppr;
    logic [POS_W-1:0]  count_base;
    logic [POS_W-1:0]  count_n;
    logic              dir_n;
    logic              step_n;
    logic              err_n;
    logic              ppr_small;

    qenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_a),
        .filt  (a_f)
    );

    qenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_b),
        .filt  (b_f)
    );

    assign ab_f = {a_f, b_f};

`ifdef QENC_INDEX_EN
    logic z_f;
    logic z_q;

    qenc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enc_z),
        .filt  (z_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) z_q <= 1'b0;
        else        z_q <= z_f;
    end

    assign index_hit = z_f & ~z_q & (ab_f == PH_0);
`else
    logic unused_enc_z;
    assign unused_enc_z = enc_z;
    assign index_hit    = 1'b0;
`endif

    assign step_k    = decode_step(ab_q, ab_f);
    assign ppr_small = (ppr <= 10'd1);
    // ceil(ppr/2) without an 11-bit intermediate.
    assign half_ppr  = {1'b0, ppr[POS_W-1:1]} + {{(POS_W-1){1'b0}}, ppr[0]};
    // A count left stranded above a freshly lowered ppr collapses to zero.
    assign count_base = (count >= ppr) ? '0 : count;

    always_comb begin
        count_n = count_base;
        dir_n   = dir;
        step_n  = 1'b0;
        err_n   = err;
        if (clear_q) begin
            count_n = '0;
            err_n   = 1'b0;
        end else if (index_hit) begin
            count_n = '0;
            if (step_k == STEP_ILLEGAL) err_n = 1'b1;
        end else begin
            case (step_k)
                STEP_UP: begin
                    step_n = 1'b1;
                    dir_n  = 1'b1;
                    if (ppr_small)                       count_n = '0;
                    else if (count_base == ppr - 10'd1)  count_n = '0;
                    else                                 count_n = count_base + 10'd1;
                end
                STEP_DOWN: begin
                    step_n = 1'b1;
                    dir_n  = 1'b0;
                    if (ppr_small)              count_n = '0;
                    else if (count_base == '0)  count_n = ppr - 10'd1;
                    else                        count_n = count_base - 10'd1;
                end
                STEP_ILLEGAL: err_n = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q     <= PH_0;
            clear_q  <= 1'b0;
            count    <= '0;
            position <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ab_q     <= ab_f;
            clear_q  <= clear;
            count    <= count_n;
            position <= $signed(count - half_ppr);
            dir      <= dir_n;
            step     <= step_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter; expected values are hand-derived.
// Index checks follow QENC_INDEX_EN when the bench is compiled with it.
module tb_quad_encoder_counter;

    logic              clk;
    logic              rst_n;
    logic              enc_a;
    logic              enc_b;
    logic              enc_z;
    logic [9:0]        ppr;
    logic              clear;
    logic [9:0]        count;
    logic signed [9:0] position;
    logic              dir;
    logic              step;
    logic              err;

    int n_pass  = 0;
    int n_total = 0;
    int step_cnt = 0;

    logic [1:0] ph [4];

    quad_encoder_counter #(.FILTER_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_z    (enc_z),
        .ppr      (ppr),
        .clear    (clear),
        .count    (count),
        .position (position),
        .dir      (dir),
        .step     (step),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (step === 1'b1) step_cnt++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_ab(input logic [1:0] v, input int hold);
        enc_a = v[1];
        enc_b = v[0];
        tick(hold);
    endtask

    task automatic do_reset(input logic [9:0] p);
        rst_n = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        enc_z = 1'b0;
        clear = 1'b0;
        ppr   = p;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0; clear = 1'b0;
        ppr = 10'd400;
        tick(2);
        n_total++;
        if ({count, position, dir, step, err} !== 23'd0)
            $display("FAIL reset_outputs: got cnt=%0d pos=%0d dir=%b step=%b err=%b want all zero",
                     count, position, dir, step, err);
        else n_pass++;
        rst_n = 1'b1;
        tick(1);
        n_total++;
        if (int'(position) !== -200)
            $display("FAIL reset_first_position: got %0d want -200", int'(position));
        else n_pass++;
    endtask

    task automatic test_forward;
        int sc0;
        int bad;
        do_reset(10'd400);
        sc0 = step_cnt;
        bad = 0;
        for (int i = 1; i <= 401; i++) begin
            drive_ab(ph[i % 4], 10);
            if (count !== 10'(i % 400)) bad++;
            if (i == 400) begin
                n_total++;
                if (count !== 10'd0) $display("FAIL fwd_wrap: got %0d want 0", count);
                else n_pass++;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL fwd_sequence: got %0d wrong counts want 0", bad);
        else n_pass++;
        n_total++;
        if (count !== 10'd1) $display("FAIL fwd_final_count: got %0d want 1", count);
        else n_pass++;
        n_total++;
        if (int'(position) !== -199) $display("FAIL fwd_position: got %0d want -199", int'(position));
        else n_pass++;
        n_total++;
        if (step_cnt - sc0 != 401) $display("FAIL fwd_step_pulses: got %0d want 401", step_cnt - sc0);
        else n_pass++;
        n_total++;
        if (dir !== 1'b1) $display("FAIL fwd_dir: got %b want 1", dir);
        else n_pass++;
    endtask

    task automatic test_reverse_wrap;
        do_reset(10'd400);
        drive_ab(2'b10, 8);
        n_total++;
        if (count !== 10'd399) $display("FAIL rev_count: got %0d want 399", count);
        else n_pass++;
        n_total++;
        if (int'(position) !== 199) $display("FAIL rev_position: got %0d want 199", int'(position));
        else n_pass++;
        n_total++;
        if (dir !== 1'b0) $display("FAIL rev_dir: got %b want 0", dir);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int sc0;
        do_reset(10'd400);
        sc0 = step_cnt;
        repeat (3) begin
            enc_a = 1'b1; tick(2);
            enc_a = 1'b0; tick(4);
        end
        tick(6);
        n_total++;
        if (step_cnt != sc0 || count !== 10'd0)
            $display("FAIL glitch_reject: got steps=%0d cnt=%0d want steps=0 cnt=0", step_cnt - sc0, count);
        else n_pass++;
        // A stable change: sampled at edge k, step must appear at edge k+5 only.
        enc_a = 1'b1;
        tick(1);
        tick(4);
        n_total++;
        if (step !== 1'b0) $display("FAIL glitch_step_early: got %b want 0 at k+4", step);
        else n_pass++;
        tick(1);
        n_total++;
        if (step !== 1'b1 || count !== 10'd399)
            $display("FAIL glitch_step_k5: got step=%b cnt=%0d want step=1 cnt=399", step, count);
        else n_pass++;
        tick(1);
        n_total++;
        if (step !== 1'b0) $display("FAIL glitch_step_width: got %b want 0 at k+6", step);
        else n_pass++;
    endtask

    task automatic test_illegal_clear;
        do_reset(10'd400);
        drive_ab(2'b01, 8);
        drive_ab(2'b10, 8);
        n_total++;
        if (err !== 1'b1 || count !== 10'd1)
            $display("FAIL illegal_err: got err=%b cnt=%0d want err=1 cnt=1", err, count);
        else n_pass++;
        // Legal 10->00 step lands in the same cycle as the registered clear.
        enc_a = 1'b0; enc_b = 1'b0;
        tick(1);
        tick(3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        n_total++;
        if (count !== 10'd0 || err !== 1'b0 || step !== 1'b0)
            $display("FAIL clear_priority: got cnt=%0d err=%b step=%b want 0 0 0", count, err, step);
        else n_pass++;
        tick(4);
        n_total++;
        if (count !== 10'd0 || int'(position) !== -200)
            $display("FAIL clear_settle: got cnt=%0d pos=%0d want 0 -200", count, int'(position));
        else n_pass++;
    endtask

    task automatic test_ppr_change;
        do_reset(10'd1000);
        for (int i = 1; i <= 500; i++) drive_ab(ph[i % 4], 6);
        tick(2);
        n_total++;
        if (count !== 10'd500) $display("FAIL ppr_pre_count: got %0d want 500", count);
        else n_pass++;
        ppr = 10'd100;
        tick(1);
        n_total++;
        if (count !== 10'd0) $display("FAIL ppr_force_zero: got %0d want 0", count);
        else n_pass++;
        tick(1);
        n_total++;
        if (int'(position) !== -50) $display("FAIL ppr_position: got %0d want -50", int'(position));
        else n_pass++;
    endtask

    task automatic test_ppr_small;
        int sc0;
        do_reset(10'd1);
        sc0 = step_cnt;
        drive_ab(2'b01, 8);
        n_total++;
        if (count !== 10'd0 || dir !== 1'b1 || step_cnt - sc0 != 1)
            $display("FAIL ppr_one: got cnt=%0d dir=%b steps=%0d want 0 1 1", count, dir, step_cnt - sc0);
        else n_pass++;
    endtask

    task automatic test_index;
        int sc0;
        logic [9:0] exp_cnt;
        do_reset(10'd400);
        for (int j = 1; j <= 3; j++) drive_ab(ph[j % 4], 6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(3);
        for (int j = 4; j <= 40; j++) drive_ab(ph[j % 4], 6);
        tick(2);
        n_total++;
        if (count !== 10'd37 || {enc_a, enc_b} !== 2'b00)
            $display("FAIL index_setup: got cnt=%0d want 37", count);
        else n_pass++;
        sc0 = step_cnt;
        enc_z = 1'b1;
        tick(1);
        tick(5);
`ifdef QENC_INDEX_EN
        exp_cnt = 10'd0;
`else
        exp_cnt = 10'd37;
`endif
        n_total++;
        if (count !== exp_cnt || step_cnt != sc0)
            $display("FAIL index_zero: got cnt=%0d steps=%0d want cnt=%0d steps=0",
                     count, step_cnt - sc0, exp_cnt);
        else n_pass++;
        enc_z = 1'b0;
        tick(6);
    endtask

    initial begin
        ph[0] = 2'b00; ph[1] = 2'b01; ph[2] = 2'b11; ph[3] = 2'b10;
        test_reset;
        test_forward;
        test_reverse_wrap;
        test_glitch;
        test_illegal_clear;
        test_ppr_change;
        test_ppr_small;
        test_index;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
